// File: rtl/bfsk_rom_reader.sv
// BFSK modulator front end: phase accumulator addresses a 64x8 sine ROM; each accepted bit yields SPS samples.
// Latency: issue cycle k -> sample_valid in k+2. Bits accepted only when idle or on a symbol's last sample.
module bfsk_rom_reader #(
  parameter int PHASE_W = 16,
  parameter int SPS     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PHASE_W-1:0] f0_word,
  input  logic [PHASE_W-1:0] f1_word,
  input  logic               bit_valid,
  input  logic               bit_data,
  output logic               bit_ready,
  output logic [5:0]         rom_addr,
  input  logic [7:0]         rom_data,
  output logic [7:0]         sample_out,
  output logic               sample_valid,
  output logic               busy,
  output logic               underrun
);

  localparam int CNT_W = $clog2(SPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] sym_word_q, sym_word_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rd_vld_q, rd_vld_d;
  logic               sample_valid_q, sample_valid_d;
  logic [7:0]         sample_out_q, sample_out_d;
  logic               underrun_q, underrun_d;
  logic               accept;

  assign bit_ready = enable && ((state_q == IDLE) || (count_q == LAST));
  assign accept    = bit_valid && bit_ready;

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    sym_word_d     = sym_word_q;
    count_d        = count_q;
    rd_vld_d       = 1'b0;
    sample_valid_d = rd_vld_q;
    sample_out_d   = sample_out_q;
    underrun_d     = 1'b0;

    if (!enable) begin
      // Abort drops the symbol and any samples still in the ROM pipeline.
      state_d        = IDLE;
      phase_d        = '0;
      count_d        = '0;
      sample_valid_d = 1'b0;
    end else begin
      if (rd_vld_q) sample_out_d = rom_data;
      if (state_q == IDLE) begin
        if (accept) begin
          state_d    = SEND;
          count_d    = '0;
          sym_word_d = bit_data ? f1_word : f0_word;
        end
      end else begin
        rd_vld_d = 1'b1;
        phase_d  = phase_q + sym_word_q;
        if (count_q == LAST) begin
          count_d = '0;
          if (accept) begin
            sym_word_d = bit_data ? f1_word : f0_word;
          end else begin
            state_d    = IDLE;
            underrun_d = 1'b1;
          end
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      sym_word_q     <= '0;
      count_q        <= '0;
      rd_vld_q       <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_out_q   <= 8'h00;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      sym_word_q     <= sym_word_d;
      count_q        <= count_d;
      rd_vld_q       <= rd_vld_d;
      sample_valid_q <= sample_valid_d;
      sample_out_q   <= sample_out_d;
      underrun_q     <= underrun_d;
    end
  end

  // Address follows the phase in IDLE too, so it also reads 0 straight out of reset.
  assign rom_addr     = phase_q[PHASE_W-1 -: 6];
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign underrun     = underrun_q;
  assign busy         = (state_q == SEND) || rd_vld_q || sample_valid_q;

endmodule

// File: doc/bfsk_rom_reader.md
BFSK_ROM_READER -- requirements
Module: bfsk_rom_reader

Interface
REQ-001 Parameter PHASE_W, 16, phase accumulator and tuning-word width.
REQ-002 Parameter SPS, 16, samples per symbol, legal range 2..256.
REQ-003 The ports SHALL be: clk  in  1  single clock, all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 enable  in  1  run/abort control; low aborts and holds idle.
REQ-006 f0_word  in  PHASE_W  tuning word for bit 0.
REQ-007 f1_word  in  PHASE_W  tuning word for bit 1.
REQ-008 bit_valid  in  1  input symbol bit offered.
REQ-009 bit_data  in  1  symbol bit value.
REQ-010 bit_ready  out  1  block can accept a bit this cycle.
REQ-011 rom_addr  out  6  address to the 64x8 synchronous-read sine ROM.
REQ-012 rom_data  in  8  ROM output, valid one clk after rom_addr.
REQ-013 sample_out  out  8  registered modulated sample.
REQ-014 sample_valid  out  1  sample_out holds a new sample this cycle.
REQ-015 busy  out  1  symbol in progress or samples in flight.
REQ-016 underrun  out  1  one-cycle pulse: symbol ended with no next bit.

Function
REQ-017 States SHALL be IDLE and SEND only.
REQ-018 Handshake: bit accepted on a rising edge where bit_valid and bit_ready are both 1; bit_valid may not depend on bit_ready.
REQ-019 bit_ready SHALL be 1 in IDLE with enable=1, 1 in SEND when sample count = SPS-1 with enable=1, else 0.
REQ-020 On accept, the block SHALL latch sym_word = bit_data ? f1_word : f0_word; f0/f1 changes mid-symbol have no effect.
REQ-021 IDLE -> SEND on accept, sample count set to 0.
REQ-022 In SEND, every cycle is an issue cycle: rom_addr = phase[PHASE_W-1:PHASE_W-6]; at the edge, phase += sym_word (mod 2^PHASE_W), count += 1.
REQ-023 At count = SPS-1: accept -> count 0, new sym_word, stay SEND (no gap); no accept -> IDLE and underrun = 1 in the next cycle.
REQ-024 Phase SHALL be continuous across symbols and across IDLE gaps; it is not cleared at symbol boundaries.
REQ-025 In IDLE, rom_addr SHALL hold the current phase's top 6 bits; no issue occurs.
REQ-026 Latency: issue in cycle k -> sample_out = rom_data captured at end of k+1, sample_valid = 1 during k+2; first sample_valid is 3 cycles after accept edge cycle.
REQ-027 Exactly SPS sample_valid pulses SHALL occur per accepted bit, in issue order.
REQ-028 busy = (state = SEND) or either pipeline valid stage set.
REQ-029 enable low in any cycle: at next edge state -> IDLE, phase -> 0, count -> 0, pipeline valids cleared (no further sample_valid), no underrun; sample_out holds value.
REQ-030 Simultaneous enable low and accept: enable low wins, bit not accepted (bit_ready already 0).

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, phase 0, count 0, sym_word 0, rom_addr 0, sample_out 0x00, sample_valid 0, underrun 0, busy 0, pipeline valids 0.
REQ-032 Reset mid-symbol SHALL discard the symbol; after release the block behaves as from power-up.

Verification
REQ-033 Single bit: enable=1, f0_word=0x0400, send bit 0 -> rom_addr 0,1,..,15 over 16 issue cycles, 16 consecutive sample_valid starting 3 cycles after accept, underrun pulse once.
REQ-034 Back-to-back: bits 0 then 1, f1_word=0x0800, bit_valid held -> second symbol addrs 16,18,..,46, 32 contiguous sample_valid, no underrun until after second symbol.
REQ-035 Wrap: four bit-0 symbols with f0_word=0x0400 -> addr reaches 63 at sample 63 then 0 at sample 64, sample stream continuous.
REQ-036 Abort: drop enable during sample 5 of a symbol -> sample_valid 0 within 2 cycles and no more pulses; re-enable and send bit 0 -> addr restarts at 0.
REQ-037 Async reset: assert rst_n mid-symbol between clock edges -> all outputs reach reset values before next edge; no sample_valid after release until new accept.
REQ-038 Word change: alter f0_word to 0x1000 during a bit-0 symbol -> addr step stays 1 until next accepted symbol, then 4.
